data_disaggregate: RTL and testbench

- Width-converting gearbox that takes 23-bit words from the aggregation stage and re-slices them into 16-bit words for the downstream 16-bit sink.
- Bits are treated as a continuous LSB-first stream. The first input bit becomes bit 0 of the first output word.
- A flush request emits any trailing partial word, zero-padded, so frame boundaries can be closed cleanly.
- Valid/ready handshake on both sides.

---
 rtl/data_agg_pkg.sv | 15 +
 rtl/data_disaggregate.sv | 93 +++++++++
 tb/tb_data_disaggregate.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_agg_pkg.sv
// Shared constants and state type for the 23-bit aggregation and
// disaggregation gearboxes.
package data_agg_pkg;

    localparam int IN_W  = 23;
    localparam int OUT_W = 16;
    localparam int BUF_W = IN_W + OUT_W - 1;
    localparam int CNT_W = 6;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/data_disaggregate.sv
// 23-to-16 bit gearbox: LSB-first bit stream re-sliced into 16-bit words,
// with a flush that drains a zero-padded trailing partial word.
module data_disaggregate
    import data_agg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_src,
    input  logic [IN_W-1:0]  data_in,
    output logic             rdy_src,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_sink,
    input  logic             rdy_sink,
    input  logic             flush,
    output logic             flush_done,
    output logic [CNT_W-1:0] fill_level
);

    state_t           r_state;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flush_done;

    logic             w_push;
    logic             w_pop;
    logic [BUF_W-1:0] w_buf_pop;
    logic [BUF_W-1:0] w_buf_nxt;
    logic [CNT_W-1:0] w_cnt_pop;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign rdy_src    = (r_state == RUN) &&
                        (r_cnt <= CNT_W'(BUF_W - IN_W));
    assign valid_sink = (r_cnt >= CNT_W'(OUT_W)) ||
                        ((r_state == FLUSH) && (r_cnt != '0));
    assign data_out   = r_buf[OUT_W-1:0];
    assign fill_level = r_cnt;
    assign flush_done = r_flush_done;

    assign w_push = valid_src & rdy_src;
    assign w_pop  = valid_sink & rdy_sink;

    // A partial word popped during flush empties the buffer entirely.
    always_comb begin
        w_buf_pop = r_buf;
        w_cnt_pop = r_cnt;
        if (w_pop) begin
            w_buf_pop = r_buf >> OUT_W;
            if (r_cnt >= CNT_W'(OUT_W))
                w_cnt_pop = r_cnt - CNT_W'(OUT_W);
            else
                w_cnt_pop = '0;
        end
        w_buf_nxt = w_buf_pop;
        w_cnt_nxt = w_cnt_pop;
        if (w_push) begin
            w_buf_nxt = w_buf_pop |
                ({{(BUF_W-IN_W){1'b0}}, data_in} << w_cnt_pop);
            w_cnt_nxt = w_cnt_pop + CNT_W'(IN_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_flush_done <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (flush)
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state      <= RUN;
                        r_flush_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Push needs cnt <= 15 and pop needs cnt >= 16 (or FLUSH, no push).
    always @(posedge clk) begin
        if (rst)
            assert (!(w_push && w_pop));
    end

endmodule

// File: tb/tb_data_disaggregate.sv
// Directed and bit-queue-modelled checks for the 23-to-16 gearbox.
module tb_data_disaggregate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_src = 1'b0;
    logic [22:0] data_in = '0;
    logic        rdy_src;
    logic [15:0] data_out;
    logic        valid_sink;
    logic        rdy_sink = 1'b0;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [5:0]  fill_level;

    int n_cmp = 0;
    int n_err = 0;

    data_disaggregate dut (
        .clk        (clk),
        .rst        (rst),
        .valid_src  (valid_src),
        .data_in    (data_in),
        .rdy_src    (rdy_src),
        .data_out   (data_out),
        .valid_sink (valid_sink),
        .rdy_sink   (rdy_sink),
        .flush      (flush),
        .flush_done (flush_done),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (valid_sink !== 1'b0 || rdy_src !== 1'b1 ||
            fill_level !== 6'd0 || data_out !== 16'h0 ||
            flush_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: got v=%b r=%b f=%0d d=%h fd=%b want 0 1 0 0000 0",
                     valid_sink, rdy_src, fill_level, data_out, flush_done);
        end
        rst = 1'b1;
        tick();
        rdy_sink = 1'b0;
        valid_src = 1'b1;
        data_in = 23'h7FFFFF;
        tick();
        valid_src = 1'b0;
        n_cmp++;
        if (fill_level !== 6'd23) begin
            n_err++;
            $display("FAIL reset_prefill: got %0d want 23", fill_level);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (valid_sink !== 1'b0 || rdy_src !== 1'b1 ||
            fill_level !== 6'd0 || data_out !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b r=%b f=%0d d=%h want 0 1 0 0000",
                     valid_sink, rdy_src, fill_level, data_out);
        end
        rst = 1'b1;
        tick();
        valid_src = 1'b1;
        data_in = 23'h000ABC;
        tick();
        valid_src = 1'b0;
        n_cmp++;
        if (fill_level !== 6'd23 || data_out !== 16'h0ABC ||
            valid_sink !== 1'b1) begin
            n_err++;
            $display("FAIL reset_after: got f=%0d d=%h v=%b want 23 0abc 1",
                     fill_level, data_out, valid_sink);
        end
        do_reset();
    endtask

    task automatic test_single();
        rdy_sink = 1'b1;
        valid_src = 1'b1;
        data_in = 23'h7FFFFF;
        tick();
        valid_src = 1'b0;
        n_cmp++;
        if (valid_sink !== 1'b1 || data_out !== 16'hFFFF) begin
            n_err++;
            $display("FAIL single_out: got v=%b d=%h want 1 ffff",
                     valid_sink, data_out);
        end
        tick();
        n_cmp++;
        if (fill_level !== 6'd7 || valid_sink !== 1'b0 ||
            rdy_src !== 1'b1 || data_out !== 16'h007F) begin
            n_err++;
            $display("FAIL single_pop: got f=%0d v=%b r=%b d=%h want 7 0 1 007f",
                     fill_level, valid_sink, rdy_src, data_out);
        end
        rdy_sink = 1'b0;
        do_reset();
    endtask

    task automatic test_backpressure();
        rdy_sink = 1'b0;
        valid_src = 1'b1;
        data_in = 23'h123456;
        tick();
        valid_src = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (data_out !== 16'h3456 || valid_sink !== 1'b1 ||
                rdy_src !== 1'b0 || fill_level !== 6'd23) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got d=%h v=%b r=%b f=%0d want 3456 1 0 23",
                         i, data_out, valid_sink, rdy_src, fill_level);
            end
            tick();
        end
        rdy_sink = 1'b1;
        tick();
        rdy_sink = 1'b0;
        n_cmp++;
        if (fill_level !== 6'd7 || valid_sink !== 1'b0 ||
            data_out !== 16'h0012) begin
            n_err++;
            $display("FAIL bp_release: got f=%0d v=%b d=%h want 7 0 0012",
                     fill_level, valid_sink, data_out);
        end
    endtask

    task automatic test_flush_partial();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (rdy_src !== 1'b0 || valid_sink !== 1'b1 ||
            data_out !== 16'h0012 || flush_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_present: got r=%b v=%b d=%h fd=%b want 0 1 0012 0",
                     rdy_src, valid_sink, data_out, flush_done);
        end
        rdy_sink = 1'b1;
        tick();
        n_cmp++;
        if (fill_level !== 6'd0 || valid_sink !== 1'b0 ||
            flush_done !== 1'b0 || rdy_src !== 1'b0) begin
            n_err++;
            $display("FAIL flush_popped: got f=%0d v=%b fd=%b r=%b want 0 0 0 0",
                     fill_level, valid_sink, flush_done, rdy_src);
        end
        tick();
        n_cmp++;
        if (flush_done !== 1'b1 || rdy_src !== 1'b1) begin
            n_err++;
            $display("FAIL flush_done: got fd=%b r=%b want 1 1",
                     flush_done, rdy_src);
        end
        tick();
        n_cmp++;
        if (flush_done !== 1'b0 || rdy_src !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pulse: got fd=%b r=%b want 0 1",
                     flush_done, rdy_src);
        end
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (valid_sink !== 1'b0 || flush_done !== 1'b0 ||
            rdy_src !== 1'b0) begin
            n_err++;
            $display("FAIL eflush_enter: got v=%b fd=%b r=%b want 0 0 0",
                     valid_sink, flush_done, rdy_src);
        end
        tick();
        n_cmp++;
        if (valid_sink !== 1'b0 || flush_done !== 1'b1 ||
            rdy_src !== 1'b1) begin
            n_err++;
            $display("FAIL eflush_done: got v=%b fd=%b r=%b want 0 1 1",
                     valid_sink, flush_done, rdy_src);
        end
        tick();
        n_cmp++;
        if (flush_done !== 1'b0) begin
            n_err++;
            $display("FAIL eflush_pulse: got %b want 0", flush_done);
        end
    endtask

    task automatic test_stream();
        bit          q[$];
        int          sent = 0;
        int          outs = 0;
        int          cyc = 0;
        logic [15:0] exp_w;
        logic        push;
        logic        pop;
        while (!(sent == 16 && q.size() == 0) && cyc < 3000) begin
            valid_src = (sent < 16) && ($urandom_range(0, 3) != 0);
            data_in = 23'($urandom);
            rdy_sink = ($urandom_range(0, 2) != 0);
            #1;
            n_cmp++;
            if (fill_level !== 6'(q.size()) ||
                valid_sink !== (q.size() >= 16) ||
                rdy_src !== (q.size() <= 15)) begin
                n_err++;
                $display("FAIL stream_state[%0d]: got f=%0d v=%b r=%b want f=%0d",
                         cyc, fill_level, valid_sink, rdy_src, q.size());
            end
            push = valid_src & rdy_src;
            pop = valid_sink & rdy_sink;
            if (pop && q.size() >= 16) begin
                for (int k = 0; k < 16; k++)
                    exp_w[k] = q.pop_front();
                n_cmp++;
                if (data_out !== exp_w) begin
                    n_err++;
                    $display("FAIL stream_word[%0d]: got %h want %h",
                             outs, data_out, exp_w);
                end
                outs++;
            end
            if (push) begin
                for (int k = 0; k < 23; k++)
                    q.push_back(data_in[k]);
                sent++;
            end
            tick();
            cyc++;
        end
        valid_src = 1'b0;
        rdy_sink = 1'b0;
        n_cmp++;
        if (cyc >= 3000) begin
            n_err++;
            $display("FAIL stream_timeout: got %0d cycles want < 3000", cyc);
        end
        n_cmp++;
        if (outs != 23 || fill_level !== 6'd0) begin
            n_err++;
            $display("FAIL stream_end: got outs=%0d f=%0d want 23 0",
                     outs, fill_level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
